// File: rtl/wd_kicker_if.sv
// wd_kicker_if -- 68k-side bus signals between the watchdog kicker and the system.
//   master (kicker): drives BUSREQ, nLDS, RW, A23Z, A22Z, M68K_ADDR_U[21:17], M68K_ADDR_L[12:1];
//                    receives BUSGNT (arbiter grant) and nRESET_IN (watchdog-driven system reset).
//   slave  (system): the mirror image.
interface wd_kicker_if;
  logic        BUSREQ;
  logic        BUSGNT;
  logic        nLDS;
  logic        RW;
  logic        A23Z;
  logic        A22Z;
  logic [4:0]  M68K_ADDR_U;
  logic [11:0] M68K_ADDR_L;
  logic        nRESET_IN;

  modport master (
    output BUSREQ, nLDS, RW, A23Z, A22Z, M68K_ADDR_U, M68K_ADDR_L,
    input  BUSGNT, nRESET_IN
  );

  modport slave (
    input  BUSREQ, nLDS, RW, A23Z, A22Z, M68K_ADDR_U, M68K_ADDR_L,
    output BUSGNT, nRESET_IN
  );
endinterface

// File: rtl/wd_kicker.sv
// wd_kicker -- periodically acquires the 68k bus and writes a byte to the watchdog at
// 0x300001, keeping the watchdog from resetting the system.
// Ports:
//   WDCLK      clock; all state changes on its rising edge
//   nRST       asynchronous active-low reset
//   EN         kicking enable
//   PERIOD     idle cycles between kicks (0 treated as 1)
//   bus        bus request/grant, strobe, direction, address, observed system reset
//   KICK_CNT   completed kicks, saturating at 255
//   RST_CNT    observed system reset pulses, saturating at 15
//   TIMEOUT    one-cycle pulse when a bus grant wait expires
module wd_kicker #(
  parameter int unsigned STROBE_LEN  = 2,
  parameter int unsigned GNT_TIMEOUT = 15
) (
  input  logic              WDCLK,
  input  logic              nRST,
  input  logic              EN,
  input  logic [3:0]        PERIOD,
  wd_kicker_if.master       bus,
  output logic [7:0]        KICK_CNT,
  output logic [3:0]        RST_CNT,
  output logic              TIMEOUT
);

  typedef enum logic [2:0] {
    StIdle, StWait, StReq, StAddr, StStrobe, StRel, StHold
  } state_e;

  localparam logic [3:0] GntLast = 4'(GNT_TIMEOUT - 1);
  localparam logic [2:0] StrbLen = 3'(STROBE_LEN);

  state_e     state_q, state_d;
  logic [3:0] period_cnt_q, period_cnt_d;
  logic [3:0] gnt_cnt_q, gnt_cnt_d;
  logic [2:0] strb_cnt_q, strb_cnt_d;
  logic [7:0] kick_cnt_q, kick_cnt_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic       timeout_q, timeout_d;
  logic [3:0] reload;
  logic       in_cycle;

  assign reload = (PERIOD == 4'd0) ? 4'd1 : PERIOD;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    gnt_cnt_d    = gnt_cnt_q;
    strb_cnt_d   = strb_cnt_q;
    kick_cnt_d   = kick_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    timeout_d    = 1'b0;
    if (!bus.nRESET_IN) begin
      // System reset overrides everything; count only the first cycle of each low pulse.
      state_d = StHold;
      if (state_q != StHold && rst_cnt_q != 4'hf) rst_cnt_d = rst_cnt_q + 4'd1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (EN) begin
            state_d      = StWait;
            period_cnt_d = reload;
          end
        end
        StWait: begin
          if (!EN) begin
            state_d = StIdle;
          end else if (period_cnt_q <= 4'd1) begin
            state_d      = StReq;
            period_cnt_d = 4'd0;
            gnt_cnt_d    = 4'd0;
          end else begin
            period_cnt_d = period_cnt_q - 4'd1;
          end
        end
        StReq: begin
          if (bus.BUSGNT) begin
            state_d   = StAddr;
            gnt_cnt_d = 4'd0;
          end else if (gnt_cnt_q == GntLast) begin
            state_d      = StWait;
            period_cnt_d = reload;
            gnt_cnt_d    = 4'd0;
            timeout_d    = 1'b1;
          end else begin
            gnt_cnt_d = gnt_cnt_q + 4'd1;
          end
        end
        StAddr: begin
          state_d    = StStrobe;
          strb_cnt_d = 3'd1;
        end
        StStrobe: begin
          if (strb_cnt_q == StrbLen) state_d = StRel;
          else strb_cnt_d = strb_cnt_q + 3'd1;
        end
        StRel: begin
          if (kick_cnt_q != 8'hff) kick_cnt_d = kick_cnt_q + 8'd1;
          if (EN) begin
            state_d      = StWait;
            period_cnt_d = reload;
          end else begin
            state_d = StIdle;
          end
        end
        StHold: begin
          if (EN) begin
            state_d      = StWait;
            period_cnt_d = reload;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge WDCLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      period_cnt_q <= 4'd0;
      gnt_cnt_q    <= 4'd0;
      strb_cnt_q   <= 3'd0;
      kick_cnt_q   <= 8'd0;
      rst_cnt_q    <= 4'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      gnt_cnt_q    <= gnt_cnt_d;
      strb_cnt_q   <= strb_cnt_d;
      kick_cnt_q   <= kick_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Bus outputs decode straight from the state register, so an async reset or entry into
  // HOLD returns them to idle without waiting for another edge. Address and RW are held
  // across ADDR..REL so they are stable for the whole strobe.
  always_comb begin
    in_cycle        = (state_q == StAddr) || (state_q == StStrobe) || (state_q == StRel);
    bus.BUSREQ      = in_cycle || (state_q == StReq);
    bus.RW          = !in_cycle;
    bus.nLDS        = (state_q != StStrobe);
    bus.A23Z        = 1'b0;
    bus.A22Z        = 1'b0;
    bus.M68K_ADDR_U = in_cycle ? 5'b11000 : 5'b00000;
    bus.M68K_ADDR_L = 12'd0;
  end

  assign KICK_CNT = kick_cnt_q;
  assign RST_CNT  = rst_cnt_q;
  assign TIMEOUT  = timeout_q;

endmodule
